// File: rtl/sdf_butterfly_stage.sv
// Radix-2 DIF single-path-delay-feedback FFT stage: butterfly against a DEPTH-deep
// feedback delay line, followed by a rounded, saturating complex twiddle multiply.
module sdf_butterfly_stage #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned FRAC  = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   input  logic signed [WIDTH-1:0] tw_re,
   input  logic signed [WIDTH-1:0] tw_im,
   output logic                    tw_en,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] out_re,
   output logic signed [WIDTH-1:0] out_im
);

   localparam int unsigned CW = (DEPTH > 1) ? $clog2(2 * DEPTH) : 1;
   localparam int unsigned PW = 2 * WIDTH + 1;
   localparam logic signed [PW-1:0] MAX_V = PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [PW-1:0] MIN_V = -MAX_V - PW'(1);
   localparam logic signed [PW-1:0] RND   = PW'(64'sd1 <<< (FRAC - 1));

   logic [CW-1:0]           cnt_q;
   logic                    primed_q;
   logic signed [WIDTH-1:0] dl_re_q [DEPTH];
   logic signed [WIDTH-1:0] dl_im_q [DEPTH];
   logic                    out_valid_q;
   logic signed [WIDTH-1:0] out_re_q, out_im_q;

   logic                    bfly;
   logic                    cand_valid;
   logic signed [WIDTH-1:0] head_re, head_im;
   logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
   logic signed [WIDTH-1:0] c_re, c_im, push_re, push_im;
   logic signed [PW-1:0]    cr, ci, tr, ti, p_re, p_im, r_re, r_im;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
      if (v > MAX_V)      return MAX_V[WIDTH-1:0];
      else if (v < MIN_V) return MIN_V[WIDTH-1:0];
      else                return v[WIDTH-1:0];
   endfunction

   // 2*DEPTH is a power of two, so the MSB of cnt marks the butterfly half.
   assign bfly    = cnt_q[CW-1] | (DEPTH == 1 && cnt_q[0]);
   assign head_re = dl_re_q[DEPTH-1];
   assign head_im = dl_im_q[DEPTH-1];

   always_comb begin
      sum_re = {head_re[WIDTH-1], head_re} + {in_re[WIDTH-1], in_re};
      sum_im = {head_im[WIDTH-1], head_im} + {in_im[WIDTH-1], in_im};
      dif_re = {head_re[WIDTH-1], head_re} - {in_re[WIDTH-1], in_re};
      dif_im = {head_im[WIDTH-1], head_im} - {in_im[WIDTH-1], in_im};
      c_re    = head_re;
      c_im    = head_im;
      push_re = in_re;
      push_im = in_im;
      if (bfly) begin
         // Dropping bit 0 of the WIDTH+1 result is the floor halving.
         c_re    = sum_re[WIDTH:1];
         c_im    = sum_im[WIDTH:1];
         push_re = dif_re[WIDTH:1];
         push_im = dif_im[WIDTH:1];
      end
      cand_valid = in_valid & (bfly | primed_q);
      cr   = PW'(c_re);
      ci   = PW'(c_im);
      tr   = PW'(tw_re);
      ti   = PW'(tw_im);
      p_re = cr * tr - ci * ti;
      p_im = cr * ti + ci * tr;
      r_re = (p_re + RND) >>> FRAC;
      r_im = (p_im + RND) >>> FRAC;
   end

   assign tw_en = cand_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dl_re_q[i] <= '0;
            dl_im_q[i] <= '0;
         end
      end else begin
         out_valid_q <= cand_valid;
         if (cand_valid) begin
            out_re_q <= sat(r_re);
            out_im_q <= sat(r_im);
         end
         if (in_valid) begin
            cnt_q <= (DEPTH == 1) ? (cnt_q ^ CW'(1)) : (cnt_q + CW'(1));
            if (bfly) primed_q <= 1'b1;
            dl_re_q[0] <= push_re;
            dl_im_q[0] <= push_im;
            for (int i = 1; i < DEPTH; i++) begin
               dl_re_q[i] <= dl_re_q[i-1];
               dl_im_q[i] <= dl_im_q[i-1];
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Directed bench for sdf_butterfly_stage at DEPTH=4: fill/butterfly ordering, floor
// halving, twiddle rounding, saturation, stalls and asynchronous reset mid-frame.
module tb_sdf_butterfly_stage;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [11:0] in_re = '0, in_im = '0, tw_re = '0, tw_im = '0;
   logic               tw_en, out_valid;
   logic signed [11:0] out_re, out_im;

   int   n_checks = 0;
   int   n_pass   = 0;
   logic got_en, got_ov;
   int   got_re, got_im;

   sdf_butterfly_stage #(.WIDTH(12), .DEPTH(4), .FRAC(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_re     (in_re),
      .in_im     (in_im),
      .tw_re     (tw_re),
      .tw_im     (tw_im),
      .tw_en     (tw_en),
      .out_valid (out_valid),
      .out_re    (out_re),
      .out_im    (out_im)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   // Drive at the falling edge, sample tw_en before and outputs #1 after the rising edge.
   task automatic step(input logic v, input int re, input int im, input int twr, input int twi);
      @(negedge clk);
      in_valid = v;
      in_re    = 12'(re);
      in_im    = 12'(im);
      tw_re    = 12'(twr);
      tw_im    = 12'(twi);
      #1 got_en = tw_en;
      @(posedge clk);
      #1;
      got_ov = out_valid;
      got_re = int'(out_re);
      got_im = int'(out_im);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      in_valid = 1'b0;
      #3;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_ov: got %b want 0", out_valid);
      else n_pass++;
      n_checks++;
      if (out_re !== 12'sd0 || out_im !== 12'sd0)
         $display("FAIL reset_out: got (%0d,%0d) want (0,0)", out_re, out_im);
      else n_pass++;
      n_checks++;
      if (tw_en !== 1'b0) $display("FAIL reset_twen: got %b want 0", tw_en);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_constant();
      int   pulses = 0;
      int   exp_v;
      logic ev;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 100, 0, 1024, 0);
         ev    = (i >= 4);
         exp_v = ((i % 8) >= 4) ? 100 : 0;
         n_checks++;
         if (got_en !== ev) $display("FAIL const_twen[%0d]: got %b want %b", i, got_en, ev);
         else n_pass++;
         n_checks++;
         if (got_ov !== ev) $display("FAIL const_ov[%0d]: got %b want %b", i, got_ov, ev);
         else n_pass++;
         if (ev) begin
            n_checks++;
            if (got_re !== exp_v || got_im !== 0)
               $display("FAIL const_out[%0d]: got (%0d,%0d) want (%0d,0)", i, got_re, got_im,
                        exp_v);
            else n_pass++;
         end
         if (got_ov) pulses++;
      end
      n_checks++;
      if (pulses !== 12) $display("FAIL const_pulses: got %0d want 12", pulses);
      else n_pass++;
   endtask

   task automatic test_floor();
      int sre[12];
      int exp_re[8];
      sre    = '{5, 2, 0, 0, 2, 5, 0, 0, 0, 0, 0, 0};
      exp_re = '{3, 3, 0, 0, 1, -2, 0, 0};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b1, sre[i], 0, 1024, 0);
         if (i >= 4) begin
            n_checks++;
            if (got_ov !== 1'b1 || got_re !== exp_re[i-4] || got_im !== 0)
               $display("FAIL floor[%0d]: got v=%b (%0d,%0d) want v=1 (%0d,0)", i, got_ov,
                        got_re, got_im, exp_re[i-4]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_round();
      do_reset();
      step(1'b1, 1, 0, 1024, 0);
      for (int i = 1; i < 4; i++) step(1'b1, 0, 0, 1024, 0);
      step(1'b1, 1, 0, 724, -724);
      n_checks++;
      if (got_ov !== 1'b1 || got_re !== 1 || got_im !== -1)
         $display("FAIL round: got v=%b (%0d,%0d) want v=1 (1,-1)", got_ov, got_re, got_im);
      else n_pass++;
   endtask

   task automatic test_saturate();
      do_reset();
      step(1'b1, -2048, 0, 1024, 0);
      step(1'b1, -2048, -2048, 1024, 0);
      step(1'b1, 0, 0, 1024, 0);
      step(1'b1, 0, 0, 1024, 0);
      step(1'b1, -2048, 0, -1024, 0);
      n_checks++;
      if (got_ov !== 1'b1 || got_re !== 2047 || got_im !== 0)
         $display("FAIL sat_pos: got v=%b (%0d,%0d) want v=1 (2047,0)", got_ov, got_re, got_im);
      else n_pass++;
      step(1'b1, -2048, -2048, 1024, 1024);
      n_checks++;
      if (got_ov !== 1'b1 || got_re !== 0 || got_im !== -2048)
         $display("FAIL sat_neg: got v=%b (%0d,%0d) want v=1 (0,-2048)", got_ov, got_re, got_im);
      else n_pass++;
   endtask

   // Shared stream: sums 5,10,15,20 then differences 3,6,9,12.
   task automatic run_stream(input string tag, input bit stall, input int n_samples);
      int sre[12];
      int exp_re[8];
      int en_cnt = 0;
      int ov_cnt = 0;
      sre    = '{8, 16, 24, 32, 2, 4, 6, 8, 0, 0, 0, 0};
      exp_re = '{5, 10, 15, 20, 3, 6, 9, 12};
      for (int i = 0; i < n_samples; i++) begin
         step(1'b1, sre[i], 0, 1024, 0);
         if (got_en) en_cnt++;
         if (got_ov) ov_cnt++;
         n_checks++;
         if (got_ov !== (i >= 4))
            $display("FAIL %s_ov[%0d]: got %b want %b", tag, i, got_ov, (i >= 4));
         else n_pass++;
         if (i >= 4) begin
            n_checks++;
            if (got_re !== exp_re[i-4] || got_im !== 0)
               $display("FAIL %s_out[%0d]: got (%0d,%0d) want (%0d,0)", tag, i, got_re, got_im,
                        exp_re[i-4]);
            else n_pass++;
         end
         if (stall && i == 5) begin
            for (int s = 0; s < 3; s++) begin
               step(1'b0, 99, 99, 1024, 0);
               n_checks++;
               if (got_en !== 1'b0 || got_ov !== 1'b0 || got_re !== 10)
                  $display("FAIL %s_stall[%0d]: got en=%b v=%b re=%0d want en=0 v=0 re=10",
                           tag, s, got_en, got_ov, got_re);
               else n_pass++;
            end
         end
      end
      if (n_samples == 12) begin
         n_checks++;
         if (en_cnt !== 8 || ov_cnt !== 8)
            $display("FAIL %s_counts: got en=%0d v=%0d want en=8 v=8", tag, en_cnt, ov_cnt);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      do_reset();
      run_stream("stall", 1'b1, 12);
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_stream("pre", 1'b0, 6);
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_re !== 12'sd0 || out_im !== 12'sd0)
         $display("FAIL midreset: got v=%b (%0d,%0d) want v=0 (0,0)", out_valid, out_re,
                  out_im);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      run_stream("restart", 1'b0, 12);
   endtask

   initial begin
      test_reset();
      test_constant();
      test_floor();
      test_round();
      test_saturate();
      test_stall();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
